// File: rtl/ha_pkg.sv
// Shared types and defaults for the half adder cell.
package ha_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef struct packed {
        logic c;
        logic s;
    } ha_res_t;

endpackage

// File: rtl/ha_core.sv
// Purely combinational half adder: {c,s} is the 2-bit sum of a and b.
module ha_core
    import ha_pkg::*;
(
    input  logic    a,
    input  logic    b,
    output ha_res_t res
);

    assign res.s = a ^ b;
    assign res.c = a & b;

endmodule

// File: rtl/ha.sv
// Half adder with combinational s/c, a one-stage registered copy with valid tracking,
// and optional saturating statistics counters enabled by defining HA_STATS_EN.
module ha
   import ha_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             b,
   input  logic             in_valid,
`ifdef HA_STATS_EN
   input  logic             stat_clr,
   output logic [CNT_W-1:0] op_cnt,
   output logic [CNT_W-1:0] carry_cnt,
`endif
   output logic             s,
   output logic             c,
   output logic             s_q,
   output logic             c_q,
   output logic             out_valid
);

   ha_res_t res;

   // One core feeds both the combinational outputs and the register stage.
   ha_core u_core (
      .a   (a),
      .b   (b),
      .res (res)
   );

   assign s = res.s;
   assign c = res.c;

   // Result registers hold their value while in_valid is low; only out_valid drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q       <= 1'b0;
         c_q       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            s_q <= res.s;
            c_q <= res.c;
         end
      end
   end

`ifdef HA_STATS_EN
   // Counters stick at all-ones instead of wrapping; clear wins over increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_cnt    <= '0;
         carry_cnt <= '0;
      end else if (stat_clr) begin
         op_cnt    <= '0;
         carry_cnt <= '0;
      end else if (in_valid) begin
         if (op_cnt != '1)
            op_cnt <= op_cnt + CNT_W'(1);
         if (res.c && (carry_cnt != '1))
            carry_cnt <= carry_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_ha.sv
// Self-checking bench for ha: directed vectors, literal expectations and a per-cycle model compare.
module tb_ha;

   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic clk_en = 1'b0;
   logic rst_n, a, b, in_valid, stat_clr;
   logic s, c, s_q, c_q, out_valid;
`ifdef HA_STATS_EN
   logic [CNT_W-1:0] op_cnt, carry_cnt;
`endif

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Model state: expected registered result, valid flag and counters.
   int exp_sum   = 0;
   bit exp_valid = 1'b0;
   int exp_ops   = 0;
   int exp_carry = 0;

   // Device under test, with the stats ports connected only when the feature is compiled in.
   ha #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .in_valid  (in_valid),
`ifdef HA_STATS_EN
      .stat_clr  (stat_clr),
      .op_cnt    (op_cnt),
      .carry_cnt (carry_cnt),
`endif
      .s         (s),
      .c         (c),
      .s_q       (s_q),
      .c_q       (c_q),
      .out_valid (out_valid)
   );

   // Gated free-running clock, started once the combinational phase is done.
   always #5 if (clk_en) clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic na, input logic nb, input logic nv, input logic nclr);
      a        = na;
      b        = nb;
      in_valid = nv;
      stat_clr = nclr;
   endtask

   task automatic nextEdge();
      @(posedge clk);
      #1;
   endtask

   // Reference behaviour: reset clears the model state immediately.
   always @(negedge rst_n) begin
      exp_sum   = 0;
      exp_valid = 1'b0;
      exp_ops   = 0;
      exp_carry = 0;
   end

   // Reference behaviour: registered result is the arithmetic sum captured on a valid edge.
   always @(posedge clk) begin
      if (rst_n) begin
         exp_valid = in_valid;
         if (in_valid)
            exp_sum = int'(a) + int'(b);
         if (stat_clr) begin
            exp_ops   = 0;
            exp_carry = 0;
         end else if (in_valid) begin
            if (exp_ops < CNT_MAX) exp_ops++;
            if (a && b && exp_carry < CNT_MAX) exp_carry++;
         end
      end
   end

   // Per-cycle comparison against the model on the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         checkOutput("comb_sum", 32'({c, s}), 32'(int'(a) + int'(b)));
         checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
         checkOutput("reg_sum", 32'({c_q, s_q}), 32'(exp_sum));
         checkOutput("sq_and_cq", 32'(s_q & c_q), 32'(0));
`ifdef HA_STATS_EN
         checkOutput("op_cnt", 32'(op_cnt), 32'(exp_ops));
         checkOutput("carry_cnt", 32'(carry_cnt), 32'(exp_carry));
`endif
      end
   end

   // Watchdog against a hung simulation.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog");
   end

   // Main directed and random sequence.
   initial begin
      logic [1:0] comb_tab [4];
      comb_tab[0] = 2'b00;
      comb_tab[1] = 2'b10;
      comb_tab[2] = 2'b10;
      comb_tab[3] = 2'b01;

      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 4; i++) begin
         a = i[1];
         b = i[0];
         #10;
         checkOutput("comb_no_clk", 32'({s, c}), 32'(comb_tab[i]));
      end
      checkOutput("rst_s_q", 32'(s_q), 32'(0));
      checkOutput("rst_c_q", 32'(c_q), 32'(0));
      checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
`ifdef HA_STATS_EN
      checkOutput("rst_op_cnt", 32'(op_cnt), 32'(0));
      checkOutput("rst_carry_cnt", 32'(carry_cnt), 32'(0));
`endif

      #3 rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      #2 clk_en = 1'b1;
      nextEdge();
      chk_en = 1'b1;

      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      nextEdge();
      checkOutput("dir_c_q", 32'(c_q), 32'(1));
      checkOutput("dir_s_q", 32'(s_q), 32'(0));
      checkOutput("dir_valid", 32'(out_valid), 32'(1));
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      nextEdge();
      checkOutput("hold_valid", 32'(out_valid), 32'(0));
      checkOutput("hold_c_q", 32'(c_q), 32'(1));
      checkOutput("hold_s_q", 32'(s_q), 32'(0));

      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      nextEdge();
      checkOutput("pre_rst_s_q", 32'(s_q), 32'(1));
      checkOutput("pre_rst_valid", 32'(out_valid), 32'(1));
      #1 rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_regs", 32'({s_q, c_q, out_valid}), 32'(0));
      nextEdge();
      checkOutput("in_rst_regs", 32'({s_q, c_q, out_valid}), 32'(0));
      #1 rst_n = 1'b1;
      nextEdge();
      checkOutput("post_rst_s_q", 32'(s_q), 32'(1));
      checkOutput("post_rst_c_q", 32'(c_q), 32'(0));
      checkOutput("post_rst_valid", 32'(out_valid), 32'(1));

`ifdef HA_STATS_EN
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      nextEdge();
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
         nextEdge();
      end
      checkOutput("sat_op_cnt", 32'(op_cnt), 32'(15));
      checkOutput("sat_carry_cnt", 32'(carry_cnt), 32'(15));
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      nextEdge();
      checkOutput("clr_op_cnt", 32'(op_cnt), 32'(0));
      checkOutput("clr_carry_cnt", 32'(carry_cnt), 32'(0));
`endif

      for (int i = 0; i < 1000; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));
         nextEdge();
      end

      @(negedge clk);
      #1 chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
